mac_sequencer: RTL and testbench

- Memory-mapped controller that owns one 3x3 MAC engine and sequences one filter-window dot product per start command.
- Holds 9 coefficients and 9 pixels written over a 10-bit word-addressed slave bus, routed by address bits [9:8] (control/coeff/data/result).
- Streams coefficient/pixel pairs to the engine, waits for its result, and appends it to a 24-entry result buffer readable by the host.

---
 rtl/mac_sequencer_if.sv | 23 ++
 rtl/mac_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_mac_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_if.sv
// Word-addressed host slave bus for the MAC sequencer.
// Reads answer one cycle later, flagged by readdatavalid.
interface mac_sequencer_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) ();
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, write, writedata, read,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/mac_sequencer.sv
// Memory-mapped sequencer for one 3x3 MAC engine: holds taps and pixels, streams
// one window per start, and appends each engine result to a host-readable buffer.
module mac_sequencer #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NUM_COEFFS   = 9,
    parameter int unsigned RESULT_DEPTH = 24,
    parameter int unsigned MAC_LATENCY  = 5
) (
    input  logic              clk,
    input  logic              reset,
    mac_sequencer_if.slave    bus,
    output logic              mac_in_valid,
    output logic [DATA_W-1:0] mac_coeff,
    output logic [DATA_W-1:0] mac_pixel,
    output logic              mac_first,
    output logic              mac_last,
    input  logic              mac_out_valid,
    input  logic [DATA_W-1:0] mac_out_data,
    output logic              done_pulse
);

    localparam int unsigned IDX_W   = ADDR_W - 2;
    localparam int unsigned TAP_W   = $clog2(NUM_COEFFS);
    localparam int unsigned PAIR_W  = $clog2(NUM_COEFFS + 1);
    localparam int unsigned BUF_W   = $clog2(RESULT_DEPTH);
    localparam int unsigned CNT_W   = $clog2(RESULT_DEPTH + 1);
    localparam int unsigned TIMEOUT = 4 * MAC_LATENCY;
    localparam int unsigned WAIT_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ROUTE_CTRL   = 2'd0;
    localparam logic [1:0] ROUTE_COEFF  = 2'd1;
    localparam logic [1:0] ROUTE_DATA   = 2'd2;
    localparam logic [1:0] ROUTE_RESULT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ_INPUT,
        S_WAIT_CALC,
        S_READ_RESULT
    } stateT;

    stateT              state;
    logic [PAIR_W-1:0]  pairIdx;
    logic [WAIT_W-1:0]  waitCnt;
    logic [CNT_W-1:0]   resultCount;
    logic [DATA_W-1:0]  resultLatch;
    logic               doneFlag;
    logic               toutErr;
    logic               wrErr;
    logic               fullErr;

    logic [DATA_W-1:0]  coeffMem  [NUM_COEFFS];
    logic [DATA_W-1:0]  pixelMem  [NUM_COEFFS];
    logic [DATA_W-1:0]  resultMem [RESULT_DEPTH];

    logic [1:0]         route;
    logic [IDX_W-1:0]   idx;
    logic [TAP_W-1:0]   tapIdx;
    logic               idxInTaps;
    logic               ctrlWr;
    logic               tapWr;
    logic               clearFlags;
    logic               clearCount;
    logic               startReq;
    logic               countRoom;
    logic [CNT_W-1:0]   countBase;
    logic [DATA_W-1:0]  status;
    logic [DATA_W-1:0]  readMux;

    assign route      = bus.address[ADDR_W-1 -: 2];
    assign idx        = bus.address[IDX_W-1:0];
    assign tapIdx     = TAP_W'(idx);
    assign idxInTaps  = (idx < IDX_W'(NUM_COEFFS));
    assign ctrlWr     = bus.write && (route == ROUTE_CTRL);
    assign tapWr      = bus.write && ((route == ROUTE_COEFF) || (route == ROUTE_DATA));
    assign clearFlags = ctrlWr && bus.writedata[2];
    assign clearCount = ctrlWr && bus.writedata[1];
    assign startReq   = ctrlWr && bus.writedata[0];
    // Count as seen by a start in the same write: the clear is applied first.
    assign countBase  = clearCount ? '0 : resultCount;
    assign countRoom  = (countBase < CNT_W'(RESULT_DEPTH));

    always_comb begin
        status              = '0;
        status[0]           = (state != S_IDLE);
        status[1]           = doneFlag;
        status[2]           = (resultCount == CNT_W'(RESULT_DEPTH));
        status[3]           = toutErr;
        status[4]           = wrErr;
        status[5]           = fullErr;
        status[8 +: CNT_W]  = resultCount;
    end

    // Read data reflects contents before any same-cycle write.
    always_comb begin
        readMux = '0;
        case (route)
            ROUTE_CTRL:  readMux = status;
            ROUTE_COEFF: if (idxInTaps) readMux = coeffMem[tapIdx];
            ROUTE_DATA:  if (idxInTaps) readMux = pixelMem[tapIdx];
            default:     if (idx < IDX_W'(resultCount)) readMux = resultMem[BUF_W'(idx)];
        endcase
    end

    // Operand and result storage carry no reset.
    always_ff @(posedge clk) begin
        if (tapWr && (state == S_IDLE) && idxInTaps) begin
            if (route == ROUTE_COEFF) coeffMem[tapIdx] <= bus.writedata;
            else                      pixelMem[tapIdx] <= bus.writedata;
        end
        if (!reset && (state == S_READ_RESULT)) begin
            resultMem[BUF_W'(countBase)] <= resultLatch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            pairIdx           <= '0;
            waitCnt           <= '0;
            resultCount       <= '0;
            resultLatch       <= '0;
            doneFlag          <= 1'b0;
            toutErr           <= 1'b0;
            wrErr             <= 1'b0;
            fullErr           <= 1'b0;
            mac_in_valid      <= 1'b0;
            mac_coeff         <= '0;
            mac_pixel         <= '0;
            mac_first         <= 1'b0;
            mac_last          <= 1'b0;
            done_pulse        <= 1'b0;
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= bus.read;
            if (bus.read) bus.readdata <= readMux;

            done_pulse  <= 1'b0;
            resultCount <= countBase;
            if (clearFlags) begin
                doneFlag <= 1'b0;
                toutErr  <= 1'b0;
                wrErr    <= 1'b0;
            end
            if (tapWr && (state != S_IDLE)) wrErr <= 1'b1;
            if (startReq && (state == S_IDLE) && !countRoom) fullErr <= 1'b1;

            // FSM updates follow flag clears so a same-cycle set wins.
            case (state)
                S_IDLE: begin
                    if (startReq && countRoom) begin
                        doneFlag     <= 1'b0;
                        mac_in_valid <= 1'b1;
                        mac_coeff    <= coeffMem[0];
                        mac_pixel    <= pixelMem[0];
                        mac_first    <= 1'b1;
                        mac_last     <= (NUM_COEFFS == 1);
                        pairIdx      <= PAIR_W'(1);
                        state        <= S_READ_INPUT;
                    end
                end
                S_READ_INPUT: begin
                    mac_first <= 1'b0;
                    if (pairIdx == PAIR_W'(NUM_COEFFS)) begin
                        mac_in_valid <= 1'b0;
                        mac_last     <= 1'b0;
                        mac_coeff    <= '0;
                        mac_pixel    <= '0;
                        waitCnt      <= '0;
                        state        <= S_WAIT_CALC;
                    end else begin
                        mac_coeff <= coeffMem[TAP_W'(pairIdx)];
                        mac_pixel <= pixelMem[TAP_W'(pairIdx)];
                        mac_last  <= (pairIdx == PAIR_W'(NUM_COEFFS - 1));
                        pairIdx   <= pairIdx + PAIR_W'(1);
                    end
                end
                S_WAIT_CALC: begin
                    if (mac_out_valid) begin
                        resultLatch <= mac_out_data;
                        done_pulse  <= 1'b1;
                        state       <= S_READ_RESULT;
                    end else if (waitCnt == WAIT_W'(TIMEOUT - 1)) begin
                        toutErr <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                    end
                end
                S_READ_RESULT: begin
                    resultCount <= countBase + CNT_W'(1);
                    doneFlag    <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: register vector table, read scoreboard,
// engine model with per-pair checking, and hand sequences for multi-cycle corners.
module tb_mac_sequencer;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NTAP   = 9;
    localparam int unsigned DEPTH  = 24;
    localparam int unsigned LAT    = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              mac_in_valid;
    logic [DATA_W-1:0] mac_coeff;
    logic [DATA_W-1:0] mac_pixel;
    logic              mac_first;
    logic              mac_last;
    logic              mac_out_valid;
    logic [DATA_W-1:0] mac_out_data;
    logic              done_pulse;

    always #5 clk = ~clk;

    mac_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busIf ();

    mac_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_COEFFS(NTAP),
        .RESULT_DEPTH(DEPTH), .MAC_LATENCY(LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (busIf),
        .mac_in_valid  (mac_in_valid),
        .mac_coeff     (mac_coeff),
        .mac_pixel     (mac_pixel),
        .mac_first     (mac_first),
        .mac_last      (mac_last),
        .mac_out_valid (mac_out_valid),
        .mac_out_data  (mac_out_data),
        .done_pulse    (done_pulse)
    );

    typedef struct {
        logic [31:0] data;
        string       name;
    } expT;

    typedef struct {
        bit          isWrite;
        logic [9:0]  addr;
        logic [31:0] data;
        string       name;
    } vecT;

    expT         expQ[$];
    vecT         vecs[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pairCnt = 0;
    int          windowCnt = 0;
    int          doneCnt = 0;
    int          firstCyc = 0;
    int          doneCyc = 0;
    int          startCyc = 0;
    int          cd = 0;
    bit          engOn = 1'b1;
    logic [31:0] engData = '0;
    logic [31:0] tbCoeff [NTAP];
    logic [31:0] tbPixel [NTAP];

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        busIf.address   = a;
        busIf.writedata = d;
        busIf.write     = 1'b1;
        tick();
        busIf.write     = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] e, input string n);
        expT x;
        x.data = e;
        x.name = n;
        expQ.push_back(x);
        busIf.address = a;
        busIf.read    = 1'b1;
        tick();
        busIf.read    = 1'b0;
    endtask

    task automatic startWin(input logic [31:0] d);
        engData  = d;
        startCyc = cyc + 1;
        wr(10'h000, 32'h1);
    endtask

    task automatic waitDone(input int prev, input string n);
        for (int i = 0; i < 200 && doneCnt == prev; i++) tick();
        check(n, 80'(doneCnt), 80'(prev + 1));
    endtask

    function automatic vecT mkVec(input bit w, input logic [9:0] a, input logic [31:0] d,
                                  input string n);
        vecT v;
        v.isWrite = w;
        v.addr    = a;
        v.data    = d;
        v.name    = n;
        return v;
    endfunction

    // Negedge monitor: read scoreboard, pair checker and engine model.
    always @(negedge clk) begin
        expT e;
        cyc++;
        if (busIf.readdatavalid) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_readdatavalid got=%0h", busIf.readdata);
            end else begin
                e = expQ.pop_front();
                check(e.name, 80'(busIf.readdata), 80'(e.data));
            end
        end
        mac_out_valid = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mac_out_valid = 1'b1;
                mac_out_data  = engData;
            end
        end
        if (mac_in_valid) begin
            if (pairCnt < int'(NTAP)) begin
                check("pair", 80'({mac_coeff, mac_pixel, mac_first, mac_last}),
                      80'({tbCoeff[pairCnt], tbPixel[pairCnt], pairCnt == 0, pairCnt == NTAP - 1}));
            end else begin
                total++;
                bad++;
                $display("FAIL extra_pair got=%0d exp<%0d", pairCnt, NTAP);
            end
            if (mac_first) firstCyc = cyc;
            if (mac_last) begin
                windowCnt++;
                pairCnt = 0;
                if (engOn) cd = LAT;
            end else begin
                pairCnt++;
            end
        end
        if (done_pulse) begin
            doneCnt++;
            doneCyc = cyc;
        end
        if (reset) begin
            pairCnt       = 0;
            cd            = 0;
            mac_out_valid = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int w;
        busIf.address   = '0;
        busIf.write     = 1'b0;
        busIf.writedata = '0;
        busIf.read      = 1'b0;
        mac_out_valid   = 1'b0;
        mac_out_data    = '0;
        reset           = 1'b1;

        for (int k = 0; k < int'(NTAP); k++) begin
            tbCoeff[k] = 32'h3f80_0000;
            tbPixel[k] = 32'(k + 1);
            vecs.push_back(mkVec(1'b1, 10'(10'h100 + k), tbCoeff[k], "wr_coeff"));
            vecs.push_back(mkVec(1'b1, 10'(10'h200 + k), tbPixel[k], "wr_pixel"));
        end
        vecs.push_back(mkVec(1'b0, 10'h100, 32'h3f80_0000, "rd_coeff0"));
        vecs.push_back(mkVec(1'b0, 10'h108, 32'h3f80_0000, "rd_coeff8"));
        vecs.push_back(mkVec(1'b0, 10'h200, 32'h0000_0001, "rd_pixel0"));
        vecs.push_back(mkVec(1'b0, 10'h208, 32'h0000_0009, "rd_pixel8"));
        vecs.push_back(mkVec(1'b1, 10'h109, 32'hDEAD_0001, "wr_coeff_idx9"));
        vecs.push_back(mkVec(1'b1, 10'h209, 32'hDEAD_0002, "wr_pixel_idx9"));
        vecs.push_back(mkVec(1'b0, 10'h109, 32'h0, "rd_coeff_idx9"));
        vecs.push_back(mkVec(1'b0, 10'h209, 32'h0, "rd_pixel_idx9"));
        vecs.push_back(mkVec(1'b0, 10'h2FF, 32'h0, "rd_pixel_idxff"));
        vecs.push_back(mkVec(1'b0, 10'h300, 32'h0, "rd_result_empty"));
        vecs.push_back(mkVec(1'b0, 10'h000, 32'h0, "status_idx9_noflag"));

        // Reset state
        repeat (3) tick();
        check("rst_mac_in_valid", 80'(mac_in_valid), 80'(0));
        check("rst_readdatavalid", 80'(busIf.readdatavalid), 80'(0));
        check("rst_done_pulse", 80'(done_pulse), 80'(0));
        reset = 1'b0;
        tick();
        rd(10'h000, 32'h0, "rst_status");

        foreach (vecs[i]) begin
            if (vecs[i].isWrite) wr(vecs[i].addr, vecs[i].data);
            else                 rd(vecs[i].addr, vecs[i].data, vecs[i].name);
        end
        tick();

        // First window: latency and result
        startWin(32'h0000_002D);
        waitDone(0, "win1_done");
        check("win1_first_latency", 80'(firstCyc - startCyc), 80'(1));
        check("win1_done_latency", 80'(doneCyc - startCyc), 80'(9 + LAT + 1));
        repeat (3) tick();
        check("win1_done_once", 80'(doneCnt), 80'(1));
        check("win1_windows", 80'(windowCnt), 80'(1));
        rd(10'h300, 32'h0000_002D, "win1_result");
        rd(10'h000, 32'h0000_0102, "win1_status");

        // Tap write while busy is dropped and flagged
        startWin(32'hA5A5_0002);
        wr(10'h103, 32'hDEAD_BEEF);
        waitDone(1, "win2_done");
        tick();
        rd(10'h103, 32'h3f80_0000, "busy_wr_dropped");
        rd(10'h000, 32'h0000_0212, "busy_wr_status");
        rd(10'h301, 32'hA5A5_0002, "win2_result");
        wr(10'h000, 32'h4);
        rd(10'h000, 32'h0000_0200, "clear_flags");

        // Engine silent: timeout after 20 wait cycles
        engOn = 1'b0;
        startWin(32'h0);
        repeat (28) tick();
        rd(10'h000, 32'h0000_0201, "tout_last_wait");
        rd(10'h000, 32'h0000_0208, "tout_status");
        check("tout_no_done", 80'(doneCnt), 80'(2));
        wr(10'h000, 32'h4);
        rd(10'h000, 32'h0000_0200, "tout_cleared");
        engOn = 1'b1;

        // Clear count while busy: result lands at index 0
        startWin(32'hC0C0_0003);
        wr(10'h000, 32'h2);
        waitDone(2, "clr_busy_done");
        tick();
        rd(10'h000, 32'h0000_0102, "clr_busy_status");
        rd(10'h300, 32'hC0C0_0003, "clr_busy_idx0");
        rd(10'h301, 32'h0, "clr_busy_idx1");

        // Fill the buffer, then a start while full
        wr(10'h000, 32'h6);
        for (int i = 0; i < int'(DEPTH); i++) begin
            p = doneCnt;
            startWin(32'(32'h1000 + i));
            waitDone(p, "fill_done");
            tick();
        end
        rd(10'h000, 32'h0000_1806, "full_status");
        w = windowCnt;
        wr(10'h000, 32'h1);
        repeat (12) tick();
        check("full_no_window", 80'(windowCnt), 80'(w));
        rd(10'h000, 32'h0000_1826, "full_err_status");
        rd(10'h300, 32'h0000_1000, "full_idx0");
        rd(10'h317, 32'h0000_1017, "full_idx23");
        rd(10'h318, 32'h0, "full_idx24");

        // Reset during the 4th input cycle, then a clean window
        startWin(32'h0000_0BAD);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_valid", 80'(mac_in_valid), 80'(0));
        check("rst_mid_first", 80'(mac_first), 80'(0));
        reset = 1'b0;
        rd(10'h000, 32'h0, "rst_mid_status");
        w = windowCnt;
        p = doneCnt;
        startWin(32'h0000_5EED);
        waitDone(p, "rst_restart_done");
        tick();
        check("rst_restart_window", 80'(windowCnt), 80'(w + 1));
        rd(10'h300, 32'h0000_5EED, "rst_restart_result");
        rd(10'h000, 32'h0000_0102, "rst_restart_status");

        repeat (3) tick();
        check("scoreboard_empty", 80'(expQ.size()), 80'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
